// File: rtl/tick_period_meter.sv
// Tick period meter: measures the clkin-cycle interval between divider ticks,
// flags tolerance against EXPECTED, detects overflow and tracks lock.
module tick_period_meter #(
   parameter int EXPECTED = 2500,
   parameter int TOL      = 2,
   parameter int LOCK_N   = 4
) (
   input  logic        clkin,
   input  logic        reset,
   input  logic        enable,
   input  logic        tick_in,
   output logic [11:0] period,
   output logic        period_valid,
   output logic        in_tol,
   output logic        overflow,
   output logic        locked
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      MEASURE
   } state_t;

   localparam logic [31:0] LO     = 32'(EXPECTED - TOL);
   localparam logic [31:0] HI     = 32'(EXPECTED + TOL);
   localparam logic [2:0]  LK_MAX = 3'(LOCK_N);
   localparam logic [11:0] CNT_OV = 12'd4094;

   state_t      state;
   logic [11:0] cnt;
   logic [2:0]  lk;

   logic [12:0] meas;
   logic [31:0] meas32;
   logic        meas_ok;
   logic [2:0]  lk_inc;

   // meas is the interval including the tick cycle itself
   always_comb begin
      meas    = {1'b0, cnt} + 13'd1;
      meas32  = {19'd0, meas};
      meas_ok = (meas32 >= LO) && (meas32 <= HI);
      lk_inc  = (lk == LK_MAX) ? lk : lk + 3'd1;
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         lk           <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         in_tol       <= 1'b0;
         overflow     <= 1'b0;
         locked       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         overflow     <= 1'b0;
         if (!enable) begin
            state  <= IDLE;
            cnt    <= '0;
            lk     <= '0;
            locked <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state <= WAIT_FIRST;
               end
               WAIT_FIRST: begin
                  if (tick_in) begin
                     cnt   <= '0;
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (tick_in) begin
                     period       <= meas[11:0];
                     period_valid <= 1'b1;
                     in_tol       <= meas_ok;
                     cnt          <= '0;
                     if (meas_ok) begin
                        lk     <= lk_inc;
                        locked <= (lk_inc == LK_MAX);
                     end else begin
                        lk     <= '0;
                        locked <= 1'b0;
                     end
                  end else if (cnt == CNT_OV) begin
                     // interval would not fit in 12 bits: resync on next tick
                     overflow <= 1'b1;
                     lk       <= '0;
                     locked   <= 1'b0;
                     cnt      <= '0;
                     state    <= WAIT_FIRST;
                  end else begin
                     cnt <= cnt + 12'd1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: lock, tolerance edges, overflow,
// boundary interval, disable and reset behaviour.
module tb_tick_period_meter;

   logic        clkin;
   logic        reset;
   logic        enable;
   logic        tick_in;
   logic [11:0] period;
   logic        period_valid;
   logic        in_tol;
   logic        overflow;
   logic        locked;

   int errors = 0;
   int checks = 0;

   tick_period_meter #(
      .EXPECTED(2500),
      .TOL     (2),
      .LOCK_N  (4)
   ) dut (
      .clkin       (clkin),
      .reset       (reset),
      .enable      (enable),
      .tick_in     (tick_in),
      .period      (period),
      .period_valid(period_valid),
      .in_tol      (in_tol),
      .overflow    (overflow),
      .locked      (locked)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock edge, then settle so outputs of that edge are visible
   task automatic cyc();
      @(posedge clkin);
      #1;
   endtask

   task automatic idle(input int n);
      tick_in = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic pulse();
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
   endtask

   task automatic chk_meas(input string tag, input int p, input logic tol,
                           input logic lck);
      chk({tag, "_pv"}, 32'(period_valid), 32'd1);
      chk({tag, "_period"}, 32'(period), 32'(p));
      chk({tag, "_in_tol"}, 32'(in_tol), 32'(tol));
      chk({tag, "_locked"}, 32'(locked), 32'(lck));
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      tick_in = 1'b0;
      #2;
      cyc();
      cyc();
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_pv", 32'(period_valid), 32'd0);
      chk("rst_in_tol", 32'(in_tol), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);

      // steady lock
      reset  = 1'b0;
      enable = 1'b1;
      cyc();
      pulse();
      chk("first_tick_pv", 32'(period_valid), 32'd0);
      idle(2499);
      pulse();
      chk_meas("t2", 2500, 1'b1, 1'b0);
      idle(1);
      chk("t2_pv_drop", 32'(period_valid), 32'd0);
      idle(2498);
      pulse();
      chk_meas("t3", 2500, 1'b1, 1'b0);
      idle(2499);
      pulse();
      chk_meas("t4", 2500, 1'b1, 1'b0);
      idle(2499);
      pulse();
      chk_meas("t5_lock", 2500, 1'b1, 1'b1);

      // tolerance edges
      idle(2501);
      pulse();
      chk_meas("tol_2502", 2502, 1'b1, 1'b1);
      idle(2502);
      pulse();
      chk_meas("tol_2503", 2503, 1'b0, 1'b0);

      // overflow
      idle(4094);
      chk("ovf_early", 32'(overflow), 32'd0);
      idle(1);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_no_pv", 32'(period_valid), 32'd0);
      chk("ovf_period_hold", 32'(period), 32'd2503);
      idle(1);
      chk("ovf_once", 32'(overflow), 32'd0);
      idle(10);
      pulse();
      chk("ovf_resync_no_pv", 32'(period_valid), 32'd0);
      idle(2499);
      pulse();
      chk_meas("ovf_after", 2500, 1'b1, 1'b0);

      // boundary interval
      idle(4094);
      chk("bnd_no_ovf_pre", 32'(overflow), 32'd0);
      pulse();
      chk_meas("bnd_4095", 4095, 1'b0, 1'b0);

      // re-lock, then disable mid-interval with a coincident tick
      for (int i = 0; i < 4; i++) begin
         idle(2499);
         pulse();
      end
      chk_meas("relock", 2500, 1'b1, 1'b1);
      idle(999);
      enable  = 1'b0;
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      chk("dis_locked", 32'(locked), 32'd0);
      chk("dis_pv", 32'(period_valid), 32'd0);
      chk("dis_period", 32'(period), 32'd2500);
      chk("dis_in_tol", 32'(in_tol), 32'd1);
      idle(3);
      pulse();
      chk("dis_idle_tick", 32'(period_valid), 32'd0);
      enable = 1'b1;
      cyc();
      pulse();
      chk("reen_first", 32'(period_valid), 32'd0);
      idle(2499);
      pulse();
      chk_meas("reen_second", 2500, 1'b1, 1'b0);

      // reset mid-measurement with a coincident tick
      idle(1199);
      reset   = 1'b1;
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      chk("mrst_period", 32'(period), 32'd0);
      chk("mrst_pv", 32'(period_valid), 32'd0);
      chk("mrst_in_tol", 32'(in_tol), 32'd0);
      chk("mrst_locked", 32'(locked), 32'd0);
      chk("mrst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      cyc();

      // back-to-back ticks
      tick_in = 1'b1;
      cyc();
      chk("b2b_first", 32'(period_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_meas("b2b", 1, 1'b0, 1'b0);
      end
      tick_in = 1'b0;
      cyc();
      chk("b2b_end_pv", 32'(period_valid), 32'd0);
      chk("b2b_end_period", 32'(period), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
